// File: rtl/axil_uart_tx_slave.sv
// AXI4-Lite slave with a UART-Lite style register map feeding a buffered serial transmitter.
// Define UART_TX_PARITY_EN to add an even-parity bit to every frame (STAT[7] reports it).
module axil_uart_tx_slave #(
    parameter int C_S00_AXI_ADDR_WIDTH = 4,
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int CLKS_PER_BIT         = 868,
    parameter int FIFO_DEPTH           = 16
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_areset,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [3:0]                        s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic                              txd,
    output logic                              interrupt
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
    localparam logic PAR_FLAG = 1'b1;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    localparam logic PAR_FLAG = 1'b0;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t                         r_state, w_state_nxt;
    logic                           r_bvalid, r_rvalid, r_ovf, r_intr_en, r_empty_q, r_irq;
    logic [C_S00_AXI_DATA_WIDTH-1:0] r_rdata;
    logic [PTR_W-1:0]               r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]               r_count;
    logic [7:0]                     r_mem [FIFO_DEPTH];
    logic [7:0]                     r_shift;
    logic [BAUD_W-1:0]              r_baud;
    logic [2:0]                     r_bit;
    logic                           w_wr_acc, w_rd_acc, w_push_req, w_push, w_pop, w_flush;
    logic                           w_ctrl_wr, w_stat_rd, w_full, w_fifo_empty, w_tx_empty;
    logic                           w_baud_end, w_txd, w_unused;
    logic [7:0]                     w_stat;

    assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr,
                        s00_axi_wdata, s00_axi_wstrb};

    assign w_wr_acc     = s00_axi_awvalid & s00_axi_wvalid & ~r_bvalid;
    assign w_rd_acc     = s00_axi_arvalid & ~r_rvalid;
    assign w_push_req   = w_wr_acc && (s00_axi_awaddr[3:2] == 2'd1) && s00_axi_wstrb[0];
    assign w_ctrl_wr    = w_wr_acc && (s00_axi_awaddr[3:2] == 2'd3);
    assign w_flush      = w_ctrl_wr && s00_axi_wdata[0];
    assign w_stat_rd    = w_rd_acc && (s00_axi_araddr[3:2] == 2'd2);
    assign w_full       = (r_count == DEPTH_C);
    assign w_fifo_empty = (r_count == '0);
    assign w_push       = w_push_req && !w_full && !w_flush;
    assign w_pop        = (r_state == S_IDLE) && !w_fifo_empty;
    assign w_tx_empty   = w_fifo_empty && (r_state == S_IDLE);
    assign w_baud_end   = (r_baud == BAUD_LAST);
    assign w_stat       = {PAR_FLAG, 1'b0, r_ovf, r_intr_en, w_full, w_tx_empty, 2'b00};

    assign s00_axi_awready = w_wr_acc;
    assign s00_axi_wready  = w_wr_acc;
    assign s00_axi_arready = w_rd_acc;
    assign s00_axi_bvalid  = r_bvalid;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_rvalid  = r_rvalid;
    assign s00_axi_rdata   = r_rdata;
    assign s00_axi_rresp   = 2'b00;
    assign txd             = w_txd;
    assign interrupt       = r_irq;

    // AXI handshakes and control/status registers
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            r_bvalid  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_ovf     <= 1'b0;
            r_intr_en <= 1'b0;
            r_empty_q <= 1'b1;
            r_irq     <= 1'b0;
        end else begin
            if (w_wr_acc)            r_bvalid <= 1'b1;
            else if (s00_axi_bready) r_bvalid <= 1'b0;
            if (w_rd_acc) begin
                r_rvalid <= 1'b1;
                r_rdata  <= (s00_axi_araddr[3:2] == 2'd2) ?
                            {{(C_S00_AXI_DATA_WIDTH-8){1'b0}}, w_stat} : '0;
            end else if (s00_axi_rready) begin
                r_rvalid <= 1'b0;
            end
            // A drop on the same edge as a STAT read must not be lost, so set wins.
            if (w_push_req && w_full && !w_flush) r_ovf <= 1'b1;
            else if (w_stat_rd)                   r_ovf <= 1'b0;
            if (w_ctrl_wr) r_intr_en <= s00_axi_wdata[4];
            r_empty_q <= w_tx_empty;
            r_irq     <= r_intr_en && w_tx_empty && !r_empty_q;
        end
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (w_push) r_mem[r_wr_ptr] <= s00_axi_wdata[7:0];
        if (w_pop)  r_shift <= r_mem[r_rd_ptr];
        else if (r_state == S_DATA && w_baud_end) r_shift <= {1'b0, r_shift[7:1]};
    end

`ifdef UART_TX_PARITY_EN
    logic r_par;
    always_ff @(posedge s00_axi_aclk) begin
        if (w_pop) r_par <= ^r_mem[r_rd_ptr];
    end
`endif

    // Serial FSM: state register and baud/bit counters
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE) begin
                r_baud <= '0;
                r_bit  <= '0;
            end else if (w_baud_end) begin
                r_baud <= '0;
                if (r_state == S_DATA) r_bit <= r_bit + 3'd1;
            end else begin
                r_baud <= r_baud + BAUD_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_txd       = 1'b1;
        case (r_state)
            S_IDLE:  if (!w_fifo_empty) w_state_nxt = S_START;
            S_START: begin
                w_txd = 1'b0;
                if (w_baud_end) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                w_txd = r_shift[0];
`ifdef UART_TX_PARITY_EN
                if (w_baud_end && r_bit == 3'd7) w_state_nxt = S_PARITY;
            end
            S_PARITY: begin
                w_txd = r_par;
                if (w_baud_end) w_state_nxt = S_STOP;
`else
                if (w_baud_end && r_bit == 3'd7) w_state_nxt = S_STOP;
`endif
            end
            S_STOP:  if (w_baud_end) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_axil_uart_tx_slave.sv
// Bench for axil_uart_tx_slave: register vector table, directed frame/FIFO/IRQ/handshake
// sequences, and randomized pushes checked by a serial-line decoder against a byte-queue model.
module tb_axil_uart_tx_slave;
    localparam int C = 4;
    localparam int D = 16;
    localparam int FRAME = 10 * C + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  awaddr = '0, araddr = '0, wstrb = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
    logic [31:0] wdata = '0;
    logic        awready, wready, bvalid, arready, rvalid, txd, interrupt;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    axil_uart_tx_slave #(
        .C_S00_AXI_ADDR_WIDTH(4), .C_S00_AXI_DATA_WIDTH(32),
        .CLKS_PER_BIT(C), .FIFO_DEPTH(D)
    ) dut (
        .s00_axi_aclk(clk), .s00_axi_areset(rst),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
        .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
        .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready), .txd(txd), .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Serial line decoder: finds a start bit, samples mid-bit, queues the byte
    int         frame_err = 0;
    int         irq_cnt = 0;
    int         mon_cnt = 0;
    logic       mon_busy = 1'b0;
    logic [7:0] mon_byte = '0;
    always @(negedge clk) begin
        if (interrupt === 1'b1) irq_cnt <= irq_cnt + 1;
        if (rst) begin
            mon_busy <= 1'b0;
        end else if (!mon_busy) begin
            if (txd === 1'b0) begin
                mon_busy <= 1'b1;
                mon_cnt  <= 1;
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            for (int j = 0; j < 8; j++)
                if (mon_cnt == C * (j + 1) + C / 2) mon_byte[j] <= txd;
            if (mon_cnt == C * 9 + C / 2) begin
                if (txd !== 1'b1) frame_err <= frame_err + 1;
                rx_q.push_back(mon_byte);
                mon_busy <= 1'b0;
            end
        end
    end

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        @(posedge clk); #1;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        while (!(awready === 1'b1 && wready === 1'b1) && n < 40) begin
            @(negedge clk); n++;
        end
        if (n >= 40) check("write_accept_timeout", 32'(n), 32'(0));
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        int n = 0;
        @(posedge clk); #1;
        araddr = a; arvalid = 1'b1;
        @(negedge clk);
        while (arready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) check("read_accept_timeout", 32'(n), 32'(0));
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (rvalid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) check("rvalid_timeout", 32'(n), 32'(0));
        check("rresp", 32'(rresp), 32'(0));
        d = rdata;
    endtask

    task automatic check_rx(input string name);
        check($sformatf("%s_nbytes", name), 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("%s_byte%0d", name, i), 32'(rx_q[i]), 32'(exp_q[i]));
        check($sformatf("%s_framing", name), 32'(frame_err), 32'(0));
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic read_stat(input string name, input logic [31:0] exp);
        logic [31:0] v;
        axi_read(4'h8, v);
        check(name, v, exp);
    endtask

    typedef struct {
        bit          is_wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [7:0]  pat, b;
        logic [3:0]  a, s;
        int          base, n, expv;

        tbl[0]  = '{0, 4'h0, 32'h0,  4'h0, 32'h00};
        tbl[1]  = '{0, 4'h4, 32'h0,  4'h0, 32'h00};
        tbl[2]  = '{0, 4'h8, 32'h0,  4'h0, 32'h04};
        tbl[3]  = '{0, 4'hC, 32'h0,  4'h0, 32'h00};
        tbl[4]  = '{1, 4'hC, 32'h10, 4'hF, 32'h00};
        tbl[5]  = '{0, 4'h8, 32'h0,  4'h0, 32'h14};
        tbl[6]  = '{1, 4'h0, 32'hFF, 4'hF, 32'h00};
        tbl[7]  = '{0, 4'h8, 32'h0,  4'h0, 32'h14};
        tbl[8]  = '{1, 4'h4, 32'hAB, 4'hE, 32'h00};
        tbl[9]  = '{0, 4'h8, 32'h0,  4'h0, 32'h14};
        tbl[10] = '{1, 4'hC, 32'h02, 4'hF, 32'h00};
        tbl[11] = '{0, 4'h8, 32'h0,  4'h0, 32'h04};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'({awready, wready, bvalid, arready, rvalid, txd, interrupt}),
              32'(7'b0000010));
        check("reset_rdata", rdata, 32'h0);
        check("reset_resp", 32'({bresp, rresp}), 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // Register map vectors
        base = irq_cnt;
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].is_wr) begin
                axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
                @(negedge clk);
                check($sformatf("tbl%0d_bresp", i), 32'({bvalid, bresp}), 32'(3'b100));
            end else begin
                axi_read(tbl[i].addr, v);
                check($sformatf("tbl%0d_rdata", i), v, tbl[i].exp);
            end
        end
        check("tbl_no_irq", 32'(irq_cnt - base), 32'(0));
        repeat (FRAME + 10) @(posedge clk);
        check_rx("tbl");

        // Exact bit timing of one frame
        pat = 8'h55;
        axi_write(4'h4, 32'h55, 4'h1);
        exp_q.push_back(pat);
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            if (k == 0 || k >= 37) expv = 1;
            else if (k <= 4)       expv = 0;
            else                   expv = int'(pat[(k - 5) / 4]);
            check($sformatf("txd_cycle%0d", k), 32'(txd), 32'(expv));
        end
        read_stat("stat_after_frame", 32'h04);
        check_rx("frame55");

        // Overflow while the first frame holds the shifter
        b = 8'($urandom);
        axi_write(4'h4, 32'(b), 4'h1);
        exp_q.push_back(b);
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            axi_write(4'h4, 32'(b), 4'h1);
            if (i < 16) exp_q.push_back(b);
        end
        read_stat("stat_full_ovf", 32'h28);
        read_stat("stat_ovf_cleared", 32'h08);
        repeat (17 * FRAME + 60) @(posedge clk);
        check_rx("overflow");
        read_stat("stat_after_overflow", 32'h04);

        // Interrupt only once the FIFO and shifter both go empty
        base = irq_cnt;
        axi_write(4'hC, 32'h10, 4'hF);
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom);
            axi_write(4'h4, 32'(b), 4'h1);
            exp_q.push_back(b);
        end
        repeat (50) @(posedge clk);
        check("irq_not_after_first", 32'(irq_cnt - base), 32'(0));
        repeat (50) @(posedge clk);
        check("irq_one_pulse", 32'(irq_cnt - base), 32'(1));
        check_rx("irq_en");
        axi_write(4'hC, 32'h00, 4'hF);
        base = irq_cnt;
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom);
            axi_write(4'h4, 32'(b), 4'h1);
            exp_q.push_back(b);
        end
        repeat (2 * FRAME + 20) @(posedge clk);
        check("irq_disabled", 32'(irq_cnt - base), 32'(0));
        check_rx("irq_dis");

        // Flush during the first frame
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            axi_write(4'h4, 32'(b), 4'h1);
            if (i == 0) exp_q.push_back(b);
        end
        axi_write(4'hC, 32'h01, 4'hF);
        repeat (60) @(posedge clk);
        check_rx("flush");
        read_stat("stat_after_flush", 32'h04);
        repeat (2 * FRAME) @(posedge clk);
        check_rx("flush_late");

        // AW before W, then B held off by bready
        bready = 1'b0;
        @(posedge clk); #1;
        awaddr = 4'hC; wdata = 32'h10; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("aw_only_wait%0d", i), 32'({awready, wready}), 32'(0));
        end
        @(posedge clk); #1 wvalid = 1'b1;
        @(negedge clk);
        check("aw_w_accept", 32'({awready, wready}), 32'(2'b11));
        @(posedge clk); #1 wdata = 32'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("b_stall%0d", i), 32'({bvalid, awready, wready}), 32'(3'b100));
        end
        read_stat("stat_during_bstall", 32'h14);
        @(negedge clk);
        check("b_stall_after_read", 32'({bvalid, awready, wready, bresp}), 32'(5'b10000));
        @(posedge clk); #1 bready = 1'b1;
        @(negedge clk);
        check("b_handshake", 32'({bvalid, awready}), 32'(2'b10));
        @(negedge clk);
        check("second_write_accept", 32'({bvalid, awready}), 32'(2'b01));
        @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
        read_stat("stat_after_second_write", 32'h04);

        // Reset in the middle of a frame loses it and empties the FIFO
        for (int i = 0; i < 2; i++) axi_write(4'h4, 32'h3C, 4'h1);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1 check("async_reset_txd", 32'(txd), 32'(1));
        @(posedge clk); #1 rst = 1'b0;
        repeat (2 * FRAME) @(posedge clk);
        check_rx("midframe_reset");
        read_stat("stat_after_reset", 32'h04);

        // Randomized pushes against the byte-queue model
        for (int r = 0; r < 3; r++) begin
            n = int'($urandom_range(4, 12));
            for (int i = 0; i < n; i++) begin
                a = ($urandom_range(0, 3) != 0) ? 4'h4 : 4'h0;
                s = 4'($urandom);
                v = $urandom;
                axi_write(a, v, s);
                if (a == 4'h4 && s[0]) exp_q.push_back(v[7:0]);
                repeat ($urandom_range(0, 30)) @(posedge clk);
            end
            repeat (n * FRAME + 60) @(posedge clk);
            check_rx($sformatf("rand%0d", r));
            read_stat($sformatf("rand%0d_stat", r), 32'h04);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
